// File: rtl/reg_file_wr_arbiter_if.sv
// Write-port bundle between the two writeback requesters, the arbiter and the
// register file / decode stall logic.
interface reg_file_wr_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic                   ReqA;
   logic [ADDR_W-1:0]      AddrA;
   logic [DATA_W-1:0]      DataA;
   logic                   AckA;
   logic                   ReqB;
   logic [ADDR_W-1:0]      AddrB;
   logic [DATA_W-1:0]      DataB;
   logic                   AckB;
   logic [ADDR_W-1:0]      Awr;
   logic [DATA_W-1:0]      Din;
   logic                   WrEn;
   logic [2**ADDR_W-1:0]   Busy;

   // Requesters, register file and decode side
   modport master (
      output ReqA, AddrA, DataA, ReqB, AddrB, DataB,
      input  AckA, AckB, Awr, Din, WrEn, Busy
   );

   // Arbiter side
   modport slave (
      input  ReqA, AddrA, DataA, ReqB, AddrB, DataB,
      output AckA, AckB, Awr, Din, WrEn, Busy
   );
endinterface

// File: rtl/reg_file_wr_arbiter.sv
// Shares the single register-file write port between ALU writeback (A) and
// load writeback (B). Each requester owns a one-entry slot; slots compete
// round-robin, except that two writes to the same register drain oldest first.
// Busy flags every register with a write still in a slot or in the issue register.
module reg_file_wr_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic                   Clk,
   input  logic                   Rst,
   reg_file_wr_arbiter_if.slave   bus
);

   // Slot stage
   logic                    full_a_p0;
   logic                    full_b_p0;
   logic [ADDR_W-1:0]       addr_a_p0;
   logic [ADDR_W-1:0]       addr_b_p0;
   logic [DATA_W-1:0]       data_a_p0;
   logic [DATA_W-1:0]       data_b_p0;
   logic                    a_older_p0;
   logic                    last_b;

   // Issue stage
   logic                    wr_en_p1;
   logic [ADDR_W-1:0]       awr_p1;
   logic [DATA_W-1:0]       din_p1;

   logic                    load_a;
   logic                    load_b;
   logic                    gnt_a;
   logic                    gnt_b;
   logic [2**ADDR_W-1:0]    busy;

   // A slot accepts only when empty; writes to r0 are acknowledged but dropped.
   assign bus.AckA = Rst & ~full_a_p0;
   assign bus.AckB = Rst & ~full_b_p0;
   assign load_a   = bus.ReqA & bus.AckA & (bus.AddrA != '0);
   assign load_b   = bus.ReqB & bus.AckB & (bus.AddrB != '0);

   // Grant selection: lone slot wins, same register goes oldest first, otherwise alternate.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (full_a_p0 && full_b_p0) begin
         if (addr_a_p0 == addr_b_p0) begin
            gnt_a = a_older_p0;
            gnt_b = ~a_older_p0;
         end else begin
            gnt_a = last_b;
            gnt_b = ~last_b;
         end
      end else begin
         gnt_a = full_a_p0;
         gnt_b = full_b_p0;
      end
   end

   // Slot occupancy, age, round-robin pointer and the issue register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         full_a_p0  <= 1'b0;
         full_b_p0  <= 1'b0;
         a_older_p0 <= 1'b1;
         last_b     <= 1'b1;
         wr_en_p1   <= 1'b0;
         awr_p1     <= '0;
         din_p1     <= '0;
      end else begin
         if (load_a)
            full_a_p0 <= 1'b1;
         else if (gnt_a)
            full_a_p0 <= 1'b0;

         if (load_b)
            full_b_p0 <= 1'b1;
         else if (gnt_b)
            full_b_p0 <= 1'b0;

         // A newcomer is younger than an occupied peer; simultaneous loads favour A.
         if (load_a && load_b)
            a_older_p0 <= 1'b1;
         else if (load_a)
            a_older_p0 <= ~full_b_p0;
         else if (load_b)
            a_older_p0 <= full_a_p0;

         wr_en_p1 <= gnt_a | gnt_b;
         if (gnt_a) begin
            awr_p1 <= addr_a_p0;
            din_p1 <= data_a_p0;
            last_b <= 1'b0;
         end else if (gnt_b) begin
            awr_p1 <= addr_b_p0;
            din_p1 <= data_b_p0;
            last_b <= 1'b1;
         end
      end
   end

   // Slot payload; meaningful only while the matching full flag is set.
   always_ff @(posedge Clk) begin
      if (load_a) begin
         addr_a_p0 <= bus.AddrA;
         data_a_p0 <= bus.DataA;
      end
      if (load_b) begin
         addr_b_p0 <= bus.AddrB;
         data_b_p0 <= bus.DataB;
      end
   end

   // Pending-write bitmap for decode stalls; r0 is never pending.
   always_comb begin
      busy = '0;
      if (full_a_p0)
         busy[addr_a_p0] = 1'b1;
      if (full_b_p0)
         busy[addr_b_p0] = 1'b1;
      if (wr_en_p1)
         busy[awr_p1] = 1'b1;
      busy[0] = 1'b0;
   end

   assign bus.WrEn = wr_en_p1;
   assign bus.Awr  = awr_p1;
   assign bus.Din  = din_p1;
   assign bus.Busy = busy;

endmodule

// File: doc/reg_file_wr_arbiter.md
# reg_file_wr_arbiter

Write-port arbiter for the 32x32 register file. It shares the single write port (Awr/Din/WrEn) between two writeback requesters:
- A: ALU writeback.
- B: memory-load writeback.

Each requester gets a one-entry holding slot with a request/acknowledge handshake. Conflicts are resolved round-robin, except that same-register writes keep arrival order. A pending-write bitmap lets decode stall on registers not yet written.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset, asynchronous, active-low
- ReqA  in  1  requester A offers a write this cycle
- AddrA  in  ADDR_W  target register for A
- DataA  in  DATA_W  write data for A
- AckA  out  1  A's slot can accept; transfer when ReqA && AckA at rising edge
- ReqB, AddrB, DataB, AckB  same as above for requester B
- Awr  out  ADDR_W  register file write address (registered)
- Din  out  DATA_W  register file write data (registered)
- WrEn  out  1  register file write enable (registered)
- Busy  out  2**ADDR_W  bit r = 1 while a write to register r is pending

## Operation
- **Slots.** One slot per requester: Full, Addr, Data, Age.
  - AckX = Rst && !FullX. There is no same-cycle drain-and-refill.
- **Accept.** On ReqX && AckX at an edge, the slot loads Addr/Data and Full=1.
  - A request with AddrX == 0 is acknowledged and discarded. No slot is loaded, no write is issued, Busy is unchanged.
- **Age.** An Age bit marks the older slot.
  - A slot loaded while the other slot is full is younger.
  - If both load at the same edge, A is older.
- **Grant.** Evaluated each cycle over full slots:
  - Exactly one full: grant it.
  - Both full, same Addr: grant the older (WAW order preserved).
  - Both full, different Addr: round-robin. Grant the requester not granted last. LastGrant resets to B, so A wins the first conflict.
  - LastGrant updates on every grant.
- **Issue.** At the edge following a grant, the granted slot clears (Full=0) and the issue register loads WrEn=1, Awr=slot Addr, Din=slot Data. With no grant, WrEn=0 at that edge and Awr/Din hold.
- **Busy.** Combinational OR of:
  - decode(AddrA) if FullA
  - decode(AddrB) if FullB
  - decode(Awr) if WrEn
  
  Bit 0 is always 0.
- **Reset.** Asynchronous reset, applicable mid-operation:
  - Slots are cleared and pending writes are dropped.
  - WrEn, Awr, Din go to 0 immediately; Busy goes to 0; LastGrant goes to B.
  - AckA/AckB are 0 while Rst is low.
  - Requests are ignored during reset.

## Timing
- Reset values: WrEn=0, Awr=0, Din=0, Busy=0, AckA=AckB=0 during reset and 1 at the first cycle after release.
- **Latency.** Accept at edge k. WrEn/Awr/Din are valid after edge k+1 if granted in cycle k..k+1. The register file captures at edge k+2.
- **Busy window.** Bit r rises after accept edge k and falls after edge k+2, when WrEn drops or the issue register moves to another address. Back-to-back issues to the same r keep it high.
- **Contention.** The loser waits one cycle per competing grant. Its Ack stays 0 until its own slot drains.
- **Throughput.** One register-file write per cycle. Each requester sustains one transfer per 2 cycles (accept, drain, re-accept).
- The issue register never stalls; the register file always accepts.

## Test plan
- **Single write.** Reset, then ReqA=1, AddrA=3, DataA=32 for one cycle.
  - AckA=1 at the accept edge.
  - Next cycle: WrEn=1, Awr=3, Din=32.
  - Busy[3] high for exactly 2 cycles.
  - A later read of reg 3 returns 32.
- **Round-robin.** Both requesters write every cycle, with AddrA=5, DataA=1 and AddrB=6, DataB=2.
  - Issue order is A,B,A,B…, starting with A after reset.
  - AckA and AckB alternate per their slot state.
- **WAW order.** ReqB with AddrB=10, DataB=2 accepted one cycle before ReqA with AddrA=10, DataA=9, and the prior grant was B.
  - B issues first (Din=2), then A (Din=9).
  - Register 10 ends at 9.
  - Busy[10] stays high until A's write completes.
- **R0 discard.** ReqA with AddrA=0, DataA=0xFFFFFFFF.
  - AckA=1, WrEn never asserts, Busy stays 0.
- **Reset mid-operation.** Both slots full (AddrA=7, AddrB=8) and Rst pulsed low between edges.
  - WrEn, Busy, AckA and AckB drop to 0 immediately.
  - Neither write reaches the register file.
  - After release, Ack=1 and the first conflict is granted to A.
